// File: rtl/memory_prefetch_pkg.sv
// memory_prefetch_pkg
//   Shared types and constants for the sequential-read prefetch buffer.
//   e_state    : controller states (IDLE, DRAIN, MISS, WRITE)
//   WORD_BYTES : bytes per memory word
//   ADDR_W     : byte-address width
//   next_word  : address of the following word (wraps modulo 2^ADDR_W)
//   sat_inc16  : 16-bit saturating increment used by the statistics counters
package memory_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    MISS  = 2'd2,
    WRITE = 2'd3
  } e_state;

  localparam int WORD_BYTES = 2;
  localparam int ADDR_W     = 26;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  // Clears the byte-select bit so every address names a whole word.
  localparam logic [ADDR_W-1:0] WORD_MASK = 26'h3FF_FFFE;

  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_STEP;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/memory_prefetch_fifo.sv
// prefetch_fifo
//   DEPTH x 16-bit circular buffer holding prefetched words in address order.
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset
//     flush           : empty the buffer (wins over push/pop)
//     push, push_data : append a word at the tail (ignored when full)
//     pop             : drop the head word (ignored when empty)
//     head_data       : word at the head
//     count           : current occupancy, 0..DEPTH
module prefetch_fifo
  import memory_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [15:0]              push_data,
  input  logic                     pop,
  output logic [15:0]              head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_s;
  logic             push_s;

  // Qualify push/pop against occupancy; a push into a full buffer is legal only alongside a pop.
  always_comb begin
    pop_s  = pop && (count_r != {CNT_W{1'b0}});
    push_s = push && ((count_r != CNT_W'(DEPTH)) || pop_s);
  end

  // Pointer, occupancy and storage update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'd0;
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/memory_prefetch.sv
// memory_prefetch
//   Sequential-read prefetch buffer between the N64 controller memory bus
//   (upstream) and the memory arbiter (downstream). A read miss fetches the
//   requested word, then successive words are fetched in the background into
//   prefetch_fifo so later sequential reads complete in one cycle. Writes and
//   non-sequential reads flush the buffer and are forwarded in order.
//   Optional: define PREFETCH_STATS_EN to add saturating hit/miss counters.
//   Ports:
//     clk, reset                 : clock, asynchronous active-low reset
//     prefetch_enable            : 0 = pass-through, no speculative reads
//     up_req/up_write/up_address/up_wdata/up_wmask : upstream request
//     up_ack, up_rdata           : upstream completion pulse and read data
//     dn_req/dn_write/dn_address/dn_wdata/dn_wmask : downstream request
//     dn_ack, dn_rdata           : downstream completion pulse and read data
//     stat_hits, stat_misses     : statistics (PREFETCH_STATS_EN only)
module memory_prefetch
  import memory_prefetch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAGE_BITS = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prefetch_enable,
  input  logic              up_req,
  input  logic              up_write,
  input  logic [ADDR_W-1:0] up_address,
  input  logic [15:0]       up_wdata,
  input  logic [1:0]        up_wmask,
  output logic              up_ack,
  output logic [15:0]       up_rdata,
  output logic              dn_req,
  output logic              dn_write,
  output logic [ADDR_W-1:0] dn_address,
  output logic [15:0]       dn_wdata,
  output logic [1:0]        dn_wmask,
  input  logic              dn_ack,
  input  logic [15:0]       dn_rdata
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  e_state            state_r;
  logic [ADDR_W-1:0] head_addr_r;
  logic [ADDR_W-1:0] next_addr_r;
  logic [ADDR_W-1:0] miss_start_r;
  logic              outstanding_r;
  logic              active_r;
  logic              up_ack_r;
  logic [15:0]       up_rdata_r;
  logic              dn_req_r;
  logic              dn_write_r;
  logic [ADDR_W-1:0] dn_address_r;
  logic [15:0]       dn_wdata_r;
  logic [1:0]        dn_wmask_r;

  logic [ADDR_W-1:0] req_addr_s;
  logic              req_valid_s;
  logic              hit_s;
  logic              redirect_s;
  logic              flush_s;
  logic              push_s;
  logic              pf_ack_s;
  logic              page_stop_s;
  logic              issue_s;
  logic [15:0]       fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (dn_rdata),
    .pop       (hit_s),
    .head_data (fifo_head_s),
    .count     (fifo_count_s)
  );

  // Request decode: hit/miss classification, FIFO control and background prefetch issue.
  always_comb begin
    req_addr_s  = up_address & WORD_MASK;
    // up_req is still high during the up_ack cycle and must not be taken as a new request.
    req_valid_s = up_req && !up_ack_r;
    pf_ack_s    = outstanding_r && dn_ack;
    // Stop at a page start unless it is where the current miss itself began.
    page_stop_s = (next_addr_r[PAGE_BITS-1:1] == {(PAGE_BITS-1){1'b0}}) &&
                  (next_addr_r != miss_start_r);
    hit_s       = 1'b0;
    redirect_s  = 1'b0;
    flush_s     = 1'b0;
    push_s      = 1'b0;
    issue_s     = 1'b0;
    if (state_r == IDLE) begin
      if (req_valid_s && !up_write && prefetch_enable &&
          (fifo_count_s != {CNT_W{1'b0}}) && (req_addr_s == head_addr_r)) begin
        hit_s = 1'b1;
      end else if (req_valid_s) begin
        redirect_s = 1'b1;
      end else begin
        redirect_s = 1'b0;
      end
      // Disabling prefetch empties the buffer once nothing more can land in it.
      flush_s = redirect_s || !prefetch_enable;
      // A prefetch landing in the same cycle as a miss is dropped by the flush.
      push_s  = pf_ack_s && prefetch_enable;
      issue_s = !redirect_s && prefetch_enable && active_r && !outstanding_r &&
                !dn_req_r && (fifo_count_s < CNT_W'(DEPTH)) && !page_stop_s;
    end else begin
      flush_s = 1'b0;
    end
  end

  // Controller FSM with registered upstream and downstream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      head_addr_r   <= {ADDR_W{1'b0}};
      next_addr_r   <= {ADDR_W{1'b0}};
      miss_start_r  <= {ADDR_W{1'b0}};
      outstanding_r <= 1'b0;
      active_r      <= 1'b0;
      up_ack_r      <= 1'b0;
      up_rdata_r    <= 16'd0;
      dn_req_r      <= 1'b0;
      dn_write_r    <= 1'b0;
      dn_address_r  <= {ADDR_W{1'b0}};
      dn_wdata_r    <= 16'd0;
      dn_wmask_r    <= 2'b00;
    end else begin
      up_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pf_ack_s) begin
            outstanding_r <= 1'b0;
            dn_req_r      <= 1'b0;
          end
          if (hit_s) begin
            up_ack_r    <= 1'b1;
            up_rdata_r  <= fifo_head_s;
            head_addr_r <= next_word(head_addr_r);
          end else if (redirect_s) begin
            active_r <= 1'b0;
            if (outstanding_r && !dn_ack) begin
              state_r <= DRAIN;
            end else if (up_write) begin
              state_r <= WRITE;
            end else begin
              state_r <= MISS;
            end
          end else if (!prefetch_enable) begin
            active_r <= 1'b0;
          end
          if (issue_s) begin
            dn_req_r      <= 1'b1;
            dn_write_r    <= 1'b0;
            dn_address_r  <= next_addr_r;
            dn_wmask_r    <= 2'b11;
            outstanding_r <= 1'b1;
            next_addr_r   <= next_word(next_addr_r);
          end
        end
        DRAIN: begin
          // The in-flight prefetch word is discarded.
          if (dn_ack) begin
            dn_req_r      <= 1'b0;
            outstanding_r <= 1'b0;
            state_r       <= up_write ? WRITE : MISS;
          end
        end
        MISS: begin
          if (!dn_req_r) begin
            dn_req_r     <= 1'b1;
            dn_write_r   <= 1'b0;
            dn_address_r <= req_addr_s;
            dn_wmask_r   <= 2'b11;
          end else if (dn_ack) begin
            dn_req_r     <= 1'b0;
            up_ack_r     <= 1'b1;
            up_rdata_r   <= dn_rdata;
            head_addr_r  <= next_word(req_addr_s);
            next_addr_r  <= next_word(req_addr_s);
            miss_start_r <= req_addr_s;
            active_r     <= 1'b1;
            state_r      <= IDLE;
          end
        end
        WRITE: begin
          if (!dn_req_r) begin
            dn_req_r     <= 1'b1;
            dn_write_r   <= 1'b1;
            dn_address_r <= req_addr_s;
            dn_wdata_r   <= up_wdata;
            dn_wmask_r   <= up_wmask;
          end else if (dn_ack) begin
            dn_req_r <= 1'b0;
            up_ack_r <= 1'b1;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign up_ack     = up_ack_r;
  assign up_rdata   = up_rdata_r;
  assign dn_req     = dn_req_r;
  assign dn_write   = dn_write_r;
  assign dn_address = dn_address_r;
  assign dn_wdata   = dn_wdata_r;
  assign dn_wmask   = dn_wmask_r;

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_hits_r;
  logic [15:0] stat_misses_r;

  // Saturating hit and miss counters; writes count as misses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_hits_r   <= 16'd0;
      stat_misses_r <= 16'd0;
    end else begin
      if (hit_s) begin
        stat_hits_r <= sat_inc16(stat_hits_r);
      end
      if (redirect_s) begin
        stat_misses_r <= sat_inc16(stat_misses_r);
      end
    end
  end

  assign stat_hits   = stat_hits_r;
  assign stat_misses = stat_misses_r;
`endif

endmodule
